// File: rtl/core_writeback.sv
// ---------------------------------------------------------------------------
// core_writeback: buffers five execution-unit results, arbitrates to 2 RF ports
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module core_writeback #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             done,
  input  logic [4:0]             wb,
  input  logic [4:0][REG_W-1:0]  rd_in,
  input  logic [4:0][WORD_W-1:0] value_in,
  output logic                   wr_a_en,
  output logic [REG_W-1:0]       wr_a_r,
  output logic [WORD_W-1:0]      wr_a_value,
  output logic                   wr_b_en,
  output logic [REG_W-1:0]       wr_b_r,
  output logic [WORD_W-1:0]      wr_b_value,
  output logic [4:0]             busy,
  output logic                   idle,
  output logic                   overflow
);

  localparam int N_UNITS = 5;

  logic [REG_W-1:0]   fifo_rd_q  [N_UNITS][2];
  logic [WORD_W-1:0]  fifo_val_q [N_UNITS][2];
  logic [N_UNITS-1:0] rptr_q, wptr_q;
  logic [1:0]         count_q [N_UNITS];
  logic [1:0]         count_d [N_UNITS];

  logic [N_UNITS-1:0] in_v, cand_v, sel_a, sel_b, deq, enq, drop;
  logic [REG_W-1:0]   cand_rd  [N_UNITS];
  logic [WORD_W-1:0]  cand_val [N_UNITS];

  logic               a_en_d, b_en_d, second_seen;
  logic [REG_W-1:0]   a_r_d, b_r_d;
  logic [WORD_W-1:0]  a_val_d, b_val_d;
  logic [4:0]         busy_d;
  logic               idle_d;

  logic               wr_a_en_q, wr_b_en_q, idle_q, overflow_q;
  logic [REG_W-1:0]   wr_a_r_q, wr_b_r_q;
  logic [WORD_W-1:0]  wr_a_value_q, wr_b_value_q;
  logic [4:0]         busy_q;

  // A non-empty FIFO always presents its head, so bypass cannot reorder a unit.
  always_comb begin
    for (int i = 0; i < N_UNITS; i++) begin
      in_v[i]     = done[i] & wb[i];
      cand_v[i]   = (count_q[i] != 2'd0) | in_v[i];
      cand_rd[i]  = (count_q[i] != 2'd0) ? fifo_rd_q[i][rptr_q[i]]  : rd_in[i];
      cand_val[i] = (count_q[i] != 2'd0) ? fifo_val_q[i][rptr_q[i]] : value_in[i];
    end
  end

  // Only the second candidate is eligible for port B; an rd clash leaves B idle.
  always_comb begin
    sel_a       = '0;
    sel_b       = '0;
    a_en_d      = 1'b0;
    b_en_d      = 1'b0;
    second_seen = 1'b0;
    a_r_d       = '0;
    a_val_d     = '0;
    b_r_d       = '0;
    b_val_d     = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (cand_v[i]) begin
        if (!a_en_d) begin
          a_en_d   = 1'b1;
          sel_a[i] = 1'b1;
          a_r_d    = cand_rd[i];
          a_val_d  = cand_val[i];
        end else if (!second_seen) begin
          second_seen = 1'b1;
          if (cand_rd[i] != a_r_d) begin
            b_en_d   = 1'b1;
            sel_b[i] = 1'b1;
            b_r_d    = cand_rd[i];
            b_val_d  = cand_val[i];
          end
        end
      end
    end
  end

  always_comb begin
    idle_d = ~a_en_d & ~b_en_d;
    for (int i = 0; i < N_UNITS; i++) begin
      deq[i]     = (sel_a[i] | sel_b[i]) & (count_q[i] != 2'd0);
      drop[i]    = in_v[i] & (count_q[i] == 2'd2) & ~deq[i];
      enq[i]     = in_v[i] & ~((sel_a[i] | sel_b[i]) & (count_q[i] == 2'd0)) & ~drop[i];
      count_d[i] = count_q[i] + {1'b0, enq[i]} - {1'b0, deq[i]};
      busy_d[i]  = (count_d[i] != 2'd0);
      idle_d     = idle_d & ~busy_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q       <= '0;
      wptr_q       <= '0;
      for (int i = 0; i < N_UNITS; i++) count_q[i] <= 2'd0;
      wr_a_en_q    <= 1'b0;
      wr_a_r_q     <= '0;
      wr_a_value_q <= '0;
      wr_b_en_q    <= 1'b0;
      wr_b_r_q     <= '0;
      wr_b_value_q <= '0;
      busy_q       <= '0;
      idle_q       <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      rptr_q       <= rptr_q ^ deq;
      wptr_q       <= wptr_q ^ enq;
      for (int i = 0; i < N_UNITS; i++) count_q[i] <= count_d[i];
      wr_a_en_q    <= a_en_d;
      wr_a_r_q     <= a_r_d;
      wr_a_value_q <= a_val_d;
      wr_b_en_q    <= b_en_d;
      wr_b_r_q     <= b_r_d;
      wr_b_value_q <= b_val_d;
      busy_q       <= busy_d;
      idle_q       <= idle_d;
      overflow_q   <= overflow_q | (|drop);
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_UNITS; i++) begin
      if (enq[i]) begin
        fifo_rd_q[i][wptr_q[i]]  <= rd_in[i];
        fifo_val_q[i][wptr_q[i]] <= value_in[i];
      end
    end
  end

  assign wr_a_en    = wr_a_en_q;
  assign wr_a_r     = wr_a_r_q;
  assign wr_a_value = wr_a_value_q;
  assign wr_b_en    = wr_b_en_q;
  assign wr_b_r     = wr_b_r_q;
  assign wr_b_value = wr_b_value_q;
  assign busy       = busy_q;
  assign idle       = idle_q;
  assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_core_writeback.sv
// ---------------------------------------------------------------------------
// tb_core_writeback: directed scoreboard bench for core_writeback
// ---------------------------------------------------------------------------
`default_nettype none

module tb_core_writeback;

  logic             clk;
  logic             rst_n;
  logic [4:0]       done;
  logic [4:0]       wb;
  logic [4:0][3:0]  rd_in;
  logic [4:0][31:0] value_in;
  logic             wr_a_en, wr_b_en, idle, overflow;
  logic [3:0]       wr_a_r, wr_b_r;
  logic [31:0]      wr_a_value, wr_b_value;
  logic [4:0]       busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        port;
    logic [3:0]  r;
    logic [31:0] v;
  } wr_t;

  wr_t exp_q[$];

  core_writeback #(.WORD_W(32), .REG_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .done       (done),
    .wb         (wb),
    .rd_in      (rd_in),
    .value_in   (value_in),
    .wr_a_en    (wr_a_en),
    .wr_a_r     (wr_a_r),
    .wr_a_value (wr_a_value),
    .wr_b_en    (wr_b_en),
    .wr_b_r     (wr_b_r),
    .wr_b_value (wr_b_value),
    .busy       (busy),
    .idle       (idle),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_u(input int u, input logic [3:0] r, input logic [31:0] v);
    rd_in[u]    = r;
    value_in[u] = v;
    done[u]     = 1'b1;
    wb[u]       = 1'b1;
  endtask

  task automatic push(input logic p, input logic [3:0] r, input logic [31:0] v);
    wr_t e;
    e.port = p;
    e.r    = r;
    e.v    = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    done = '0;
    wb   = '0;
  endtask

  // Every observed write must match the oldest expected write, port included.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (wr_a_en) begin
        chk("sb_pending_a", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_a_rec", 64'({1'b0, wr_a_r, wr_a_value}), 64'(e));
        end
      end
      if (wr_b_en) begin
        chk("sb_pending_b", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_b_rec", 64'({1'b1, wr_b_r, wr_b_value}), 64'(e));
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    done     = '0;
    wb       = '0;
    rd_in    = '0;
    value_in = '0;
    tick();
    tick();
    chk("rst_a_en", 64'(wr_a_en), 64'd0);
    chk("rst_b_en", 64'(wr_b_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    tick();

    // single alu_a result, bypass path
    set_u(3, 4'd5, 32'hDEAD_BEEF);
    push(1'b0, 4'd5, 32'hDEAD_BEEF);
    tick();
    chk("single_a_en", 64'(wr_a_en), 64'd1);
    chk("single_a_r", 64'(wr_a_r), 64'd5);
    chk("single_a_val", 64'(wr_a_value), 64'hDEAD_BEEF);
    chk("single_b_en", 64'(wr_b_en), 64'd0);
    chk("single_busy", 64'(busy), 64'd0);
    chk("single_idle", 64'(idle), 64'd0);
    tick();
    chk("single_idle_after", 64'(idle), 64'd1);

    // three results, third queues behind the two ports
    set_u(1, 4'd1, 32'h11);
    set_u(3, 4'd2, 32'h33);
    set_u(4, 4'd3, 32'h44);
    push(1'b0, 4'd1, 32'h11);
    push(1'b1, 4'd2, 32'h33);
    push(1'b0, 4'd3, 32'h44);
    tick();
    chk("three_a_en", 64'(wr_a_en), 64'd1);
    chk("three_b_en", 64'(wr_b_en), 64'd1);
    chk("three_busy1", 64'(busy), 64'h10);
    tick();
    chk("three_a_r2", 64'(wr_a_r), 64'd3);
    chk("three_b_en2", 64'(wr_b_en), 64'd0);
    chk("three_busy2", 64'(busy), 64'd0);
    tick();
    chk("three_idle", 64'(idle), 64'd1);

    // same destination: port B must idle
    set_u(3, 4'd7, 32'hA3);
    set_u(4, 4'd7, 32'hA4);
    push(1'b0, 4'd7, 32'hA3);
    push(1'b0, 4'd7, 32'hA4);
    tick();
    chk("samerd_a_en", 64'(wr_a_en), 64'd1);
    chk("samerd_b_en", 64'(wr_b_en), 64'd0);
    chk("samerd_busy", 64'(busy), 64'h10);
    tick();
    chk("samerd_a_val2", 64'(wr_a_value), 64'hA4);
    chk("samerd_b_en2", 64'(wr_b_en), 64'd0);
    tick();

    // overflow on alu_b while units 0/1 hold both ports
    for (int k = 0; k < 3; k++) begin
      set_u(0, 4'd1, 32'h100 + 32'(k));
      set_u(1, 4'd2, 32'h200 + 32'(k));
      set_u(4, 4'd8 + 4'(k), 32'h80 + 32'(k));
      push(1'b0, 4'd1, 32'h100 + 32'(k));
      push(1'b1, 4'd2, 32'h200 + 32'(k));
      tick();
      if (k == 1) chk("ovf_full_no_flag", 64'(overflow), 64'd0);
    end
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_busy", 64'(busy), 64'h10);
    push(1'b0, 4'd8, 32'h80);
    tick();
    chk("ovf_drain1_r", 64'(wr_a_r), 64'd8);
    push(1'b0, 4'd9, 32'h81);
    tick();
    chk("ovf_drain2_r", 64'(wr_a_r), 64'd9);
    chk("ovf_drain_busy", 64'(busy), 64'd0);
    tick();
    chk("ovf_sticky", 64'(overflow), 64'd1);
    chk("ovf_idle", 64'(idle), 64'd1);

    // done without writeback is dropped
    done[2]     = 1'b1;
    wb[2]       = 1'b0;
    rd_in[2]    = 4'd6;
    value_in[2] = 32'h66;
    tick();
    chk("nowb_a_en", 64'(wr_a_en), 64'd0);
    chk("nowb_busy", 64'(busy), 64'd0);
    chk("nowb_idle", 64'(idle), 64'd1);

    // reset with three entries queued across FIFOs 3 and 4
    set_u(0, 4'd1, 32'h501);
    set_u(1, 4'd2, 32'h502);
    set_u(3, 4'd3, 32'h503);
    set_u(4, 4'd4, 32'h504);
    push(1'b0, 4'd1, 32'h501);
    push(1'b1, 4'd2, 32'h502);
    tick();
    set_u(0, 4'd1, 32'h601);
    set_u(1, 4'd2, 32'h602);
    set_u(4, 4'd5, 32'h605);
    push(1'b0, 4'd1, 32'h601);
    push(1'b1, 4'd2, 32'h602);
    tick();
    chk("prerst_busy", 64'(busy), 64'h18);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    tick();
    chk("midrst_a_en", 64'(wr_a_en), 64'd0);
    chk("midrst_b_en", 64'(wr_b_en), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_idle", 64'(idle), 64'd1);
    chk("midrst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("postrst_a_en", 64'(wr_a_en), 64'd0);
    chk("postrst_idle", 64'(idle), 64'd1);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
